// File: rtl/cond_unit.sv
// cond_unit
//
// Conditional-execution unit for a multicycle ARM-style processor. It holds
// the architectural flag register, evaluates the instruction condition field
// against those flags, registers the result as CondEx, and gates the
// FSM/decode write requests with it.
//
// Ports
//   clk       in   1  system clock, rising-edge active
//   reset     in   1  asynchronous reset, active low
//   Cond      in   4  instruction condition field (Instr[31:28])
//   ALUFlags  in   4  ALU result flags {N,Z,C,V}
//   FlagW     in   2  flag-write request: [1] -> N,Z ; [0] -> C,V
//   PCS       in   1  decode request to write the PC
//   NextPC    in   1  unconditional PC-increment request (never gated)
//   RegW      in   1  register-write request
//   MemW      in   1  memory-write request
//   PCWrite   out  1  gated PC write enable
//   RegWrite  out  1  gated register-file write enable
//   MemWrite  out  1  gated data-memory write enable
//   Flags     out  4  architectural flags {N,Z,C,V}
//   CondEx    out  1  registered condition-pass bit

module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_pass;
    logic [1:0] flag_write;

    // Evaluation always uses the registered flags, never ALUFlags, so an
    // instruction that updates the flags sees the pre-update values and
    // there is no combinational path from the ALU into the write enables.
    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    // NOTE: a default assignment before the case keeps every path driven,
    // so this stays pure combinational logic with no inferred latch.
    always_comb begin
        cond_pass = 1'b1;
        case (cond_t'(Cond))
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = ~flag_v;
            COND_HI: cond_pass = flag_c & ~flag_z;
            COND_LS: cond_pass = ~flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            default: cond_pass = 1'b1;   // AL, and 1111 treated as AL
        endcase
    end

    // An unknown request ANDed with a failing condition resolves to 0, and
    // an unknown enable falls through to the hold branch below.
    assign flag_write = FlagW & {2{cond_pass}};

    // NOTE: non-blocking assignments here so every flop samples the values
    // present before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags  <= 4'b0000;
            CondEx <= 1'b0;
        end else begin
            CondEx <= cond_pass;
            if (flag_write[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (flag_write[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // CondEx clears asynchronously on reset, so the gated enables drop at
    // once; NextPC bypasses the gate so sequential fetch always proceeds.
    assign PCWrite  = (PCS & CondEx) | NextPC;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit
//
// Self-checking bench for cond_unit. The full Cond x Flags sweep pushes the
// expected CondEx into a scoreboard queue as each condition is driven and
// pops it after the clock edge that registers it; the directed scenarios
// compare against constants.

module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondEx;

    int n_checks = 0;
    int n_fails  = 0;

    logic exp_q[$];

    cond_unit dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference condition table, written from the condition-code definitions.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // One rising edge, then settle 1 time unit so outputs are sampled and
    // inputs changed well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the flag register through an always-executed flag-setting op.
    task automatic set_flags(input logic [3:0] f);
        Cond     = 4'b1110;
        FlagW    = 2'b11;
        ALUFlags = f;
        tick();
        FlagW    = 2'b00;
    endtask

    initial begin
        reset    = 1'b0;
        Cond     = 4'b0000;
        ALUFlags = 4'b0000;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        NextPC   = 1'b0;
        RegW     = 1'b1;
        MemW     = 1'b1;

        // Reset state, observed before any clock edge.
        #2;
        check("rst_flags",    Flags,           4'b0000);
        check("rst_condex",   4'(CondEx),      4'd0);
        check("rst_regwrite", 4'(RegWrite),    4'd0);
        check("rst_memwrite", 4'(MemWrite),    4'd0);
        check("rst_pcwrite0", 4'(PCWrite),     4'd0);
        NextPC = 1'b1;
        #1;
        check("rst_pcwrite1", 4'(PCWrite),     4'd1);
        NextPC = 1'b0;
        MemW   = 1'b0;
        tick();
        check("rst_hold_flags", Flags, 4'b0000);

        // Release; first edge evaluates with Flags=0000. NE passes.
        reset = 1'b1;
        Cond  = 4'b0001;
        tick();
        check("post_rst_condex", 4'(CondEx), 4'd1);

        // EQ with Z clear fails, with Z set passes.
        Cond = 4'b0000;
        tick();
        check("eq_fail_condex",   4'(CondEx),   4'd0);
        check("eq_fail_regwrite", 4'(RegWrite), 4'd0);
        set_flags(4'b0100);
        Cond = 4'b0000;
        tick();
        check("eq_pass_condex",   4'(CondEx),   4'd1);
        check("eq_pass_regwrite", 4'(RegWrite), 4'd1);

        // Independent flag halves.
        set_flags(4'b0000);
        Cond     = 4'b1110;
        FlagW    = 2'b10;
        ALUFlags = 4'b1111;
        tick();
        check("fw_nz_only", Flags, 4'b1100);
        FlagW    = 2'b01;
        ALUFlags = 4'b0011;
        tick();
        check("fw_cv_only", Flags, 4'b1111);
        FlagW    = 2'b11;
        ALUFlags = 4'b1001;
        tick();
        check("fw_both", Flags, 4'b1001);
        FlagW = 2'b00;

        // Same-cycle update uses pre-update flags: EQ passes on old Z=1,
        // clears Z, and the next EQ evaluation fails.
        set_flags(4'b0100);
        Cond     = 4'b0000;
        FlagW    = 2'b11;
        ALUFlags = 4'b0000;
        tick();
        check("preupd_condex", 4'(CondEx), 4'd1);
        check("preupd_flags",  Flags,      4'b0000);
        FlagW = 2'b00;
        tick();
        check("postupd_condex", 4'(CondEx), 4'd0);

        // PC gating.
        set_flags(4'b0000);
        RegW   = 1'b0;
        PCS    = 1'b1;
        NextPC = 1'b0;
        Cond   = 4'b0001;
        tick();
        check("pc_ne_pass", 4'(PCWrite), 4'd1);
        Cond = 4'b0000;
        tick();
        check("pc_eq_fail", 4'(PCWrite), 4'd0);
        NextPC = 1'b1;
        #1;
        check("pc_nextpc", 4'(PCWrite), 4'd1);
        NextPC = 1'b0;
        PCS    = 1'b0;

        // Failing condition blocks flag write and memory write.
        Cond     = 4'b0000;
        FlagW    = 2'b11;
        ALUFlags = 4'b0100;
        MemW     = 1'b1;
        tick();
        check("fail_flags_hold", Flags,         4'b0000);
        check("fail_memwrite",   4'(MemWrite),  4'd0);
        MemW = 1'b1;
        FlagW = 2'bxx;
        tick();
        check("x_flagw_hold", Flags, 4'b0000);
        FlagW = 2'b00;
        MemW  = 1'b0;

        // Full Cond x Flags sweep through the scoreboard.
        RegW = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                set_flags(4'(f));
                Cond = 4'(c);
                exp_q.push_back(cond_model(4'(c), 4'(f)));
                tick();
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 4'd1, 4'd0);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check("sweep_condex",   4'(CondEx),   4'(e));
                    check("sweep_regwrite", 4'(RegWrite), 4'(e));
                end
            end
        end
        check("sb_empty", {3'b000, exp_q.size() == 0}, 4'd1);

        // Asynchronous reset between edges suppresses pending writes.
        set_flags(4'b1111);
        Cond   = 4'b1110;
        RegW   = 1'b1;
        NextPC = 1'b1;
        tick();
        check("pre_arst_regwrite", 4'(RegWrite), 4'd1);
        check("pre_arst_flags",    Flags,        4'b1111);
        #2;
        reset = 1'b0;
        #1;
        check("arst_flags",    Flags,         4'b0000);
        check("arst_condex",   4'(CondEx),    4'd0);
        check("arst_regwrite", 4'(RegWrite),  4'd0);
        check("arst_pcwrite",  4'(PCWrite),   4'd1);
        tick();
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL expose these ports, as name, direction, width, meaning:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Cond  in  4  condition field of the current instruction (Instr[31:28]).
- ALUFlags  in  4  ALU result flags {N,Z,C,V}; [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  in  2  flag-write request from decode; [1] covers N,Z and [0] covers C,V.
- PCS  in  1  decode request to write the PC (branch, or write to R15).
- NextPC  in  1  FSM unconditional PC-increment request.
- RegW  in  1  FSM register-write request.
- MemW  in  1  FSM memory-write request.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated data-memory write enable.
- Flags  out  4  architectural flag register {N,Z,C,V}.
- CondEx  out  1  registered condition-pass bit used for gating.

Function
REQ-002 The block SHALL compute a combinational pass bit, CondPass, from Cond and the current Flags (not ALUFlags).
REQ-003 CondPass SHALL follow this table: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-004 CondPass SHALL continue the table: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (treated as AL).
REQ-005 CondEx SHALL be a flop loaded with CondPass on every rising clk edge, giving exactly one cycle of latency.
REQ-006 The internal flag-write enables SHALL be FlagWrite[1] = FlagW[1] & CondPass and FlagWrite[0] = FlagW[0] & CondPass.
REQ-007 On a rising edge with FlagWrite[1]=1, Flags[3:2] SHALL load ALUFlags[3:2]; otherwise they SHALL hold.
REQ-008 On a rising edge with FlagWrite[0]=1, Flags[1:0] SHALL load ALUFlags[1:0]; otherwise they SHALL hold.
REQ-009 The two flag halves SHALL update independently in the same cycle.
REQ-010 PCWrite SHALL equal (PCS & CondEx) | NextPC, so NextPC is never gated.
REQ-011 RegWrite SHALL equal RegW & CondEx, and MemWrite SHALL equal MemW & CondEx.
REQ-012 All outputs SHALL be glitch-free functions of registered state and current inputs, with no combinational path from ALUFlags to any write enable.
REQ-013 When a flag update and a condition evaluation fall in the same cycle, CondPass SHALL use the pre-update Flags; the new Flags SHALL be visible from the next cycle.
REQ-014 Undefined input values (X on FlagW, RegW or MemW) SHALL NOT corrupt Flags when the corresponding write enable is 0.

Reset
REQ-015 While reset=0, Flags SHALL be 4'b0000 and CondEx SHALL be 0, asynchronously and without waiting for clk.
REQ-016 While reset=0, RegWrite and MemWrite SHALL be 0, and PCWrite SHALL equal NextPC.
REQ-017 If reset asserts in the middle of an instruction, any pending gated write SHALL be suppressed immediately.
REQ-018 After reset deasserts, the first clk edge SHALL load CondEx from CondPass evaluated with Flags=0000.
REQ-019 Reset release SHALL be treated as synchronous to clk by the integrator; the block SHALL contain no reset synchronizer.

Verification
REQ-020 Scenario: Flags=0000, Cond=0000 (EQ), RegW=1 -> after one edge CondEx=0 and RegWrite=0; with Flags=0100 and the same stimulus -> CondEx=1 and RegWrite=1.
REQ-021 Scenario: all 16 Cond codes crossed with all 16 Flags values -> CondEx matches the REQ-003/004 table in every case (256 checks).
REQ-022 Scenario: Cond=1110, FlagW=2'b10, ALUFlags=1111 with one edge -> Flags=1100; then FlagW=2'b01, ALUFlags=0011 with one edge -> Flags=1111.
REQ-023 Scenario: Flags=0000, Cond=0001 (NE), PCS=1, NextPC=0 -> PCWrite=1 one cycle after CondEx loads; with Cond=0000 -> PCWrite=0; with NextPC=1 and CondEx=0 -> PCWrite=1.
REQ-024 Scenario: Cond=0000, Flags=0000 (fail), FlagW=2'b11, ALUFlags=0100 -> Flags stay 0000 and MemW=1 yields MemWrite=0.
REQ-025 Scenario: Flags=1111, CondEx=1, RegW=1, then reset driven low between edges -> Flags=0000, CondEx=0, RegWrite=0 immediately, before the next edge.
